return_stack_param: RTL

Parametrised hardware return-address stack for the PUC CPU control path, replacing the fixed 16-entry, 4-bit-offset stack. It records `called_from + 1` on every call and presents the current return address to the fetch stage. It generalises PC width and depth and adds a selectable overflow policy. It also reports occupancy and full/empty status, keeps sticky overflow/underflow error flags, and defines behaviour for simultaneous call and return.

---
 rtl/return_stack_param.sv | 63 ++++++
 1 files changed

// File: rtl/return_stack_param.sv
// return_stack_param: parametrised return-address stack; call/ret/called_from/clear_errors in, return_to/depth/empty/full/overflow/underflow out
module return_stack_param #(
  parameter int PC_WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int WRAP_ON_OVERFLOW = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       call,
  input  logic                       ret,
  input  logic [PC_WIDTH-1:0]        called_from,
  input  logic                       clear_errors,
  output logic [PC_WIDTH-1:0]        return_to,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic WRAP = WRAP_ON_OVERFLOW != 0;
  logic [PC_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] top, next_top, prev_top, top_n, wr_idx;
  logic [CW-1:0] cnt_n;
  logic [PC_WIDTH-1:0] push_val;
  logic push, pop, both, wr_en, adv, grow, shrink, ovf_ev, unf_ev;
  always_comb begin
    push = call & ~ret;
    pop = ret & ~call;
    both = call & ret;
    push_val = called_from + PC_WIDTH'(1);
    next_top = (top == PW'(DEPTH - 1)) ? '0 : top + 1'b1;
    prev_top = (top == '0) ? PW'(DEPTH - 1) : top - 1'b1;
    adv = (push & (~full | WRAP)) | (both & empty);
    grow = (push & ~full) | (both & empty);
    shrink = pop & ~empty;
    wr_en = adv | both;
    wr_idx = (both & ~empty) ? top : next_top;
    top_n = adv ? next_top : shrink ? prev_top : top;
    cnt_n = grow ? depth + 1'b1 : shrink ? depth - 1'b1 : depth;
    ovf_ev = push & full;
    unf_ev = ret & empty;
    empty = depth == '0;
    full = depth == CW'(DEPTH);
    return_to = empty ? '0 : mem[top];
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      top <= '0;
      depth <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top <= top_n;
      depth <= cnt_n;
      overflow <= (overflow & ~clear_errors) | ovf_ev;
      underflow <= (underflow & ~clear_errors) | unf_ev;
    end
  end
  always_ff @(posedge clock)
    if (reset && wr_en) mem[wr_idx] <= push_val;
endmodule
